// File: rtl/dmem_responder_pkg.sv
// Shared SoC definitions for the data-memory path.
// Bus widths, memory map defaults and responder FSM encodings.
package dmem_responder_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_BASE = 32'h0000_1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word RAM with per-byte write enables and registered read.
// Shared by the data responder and the instruction memory.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [STRB_W-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store target with fixed wait states.
// Accepts one word request, waits, then holds the response until taken.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LD = (WAIT_CYCLES > 0) ?
                                      4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t state_q;
    dmem_state_t state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        rd_sel_q;

    logic [31:0] offset;
    logic        fault;
    logic        accept;
    logic        access;
    logic        rsp_hs;
    logic [31:0] ram_q;

    assign offset    = addr_q - BASE_ADDR;
    assign fault     = (addr_q[1:0] != 2'b00) || (offset >= SPAN);
    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    // RESP begins with one access cycle so the registered RAM read can land
    assign access    = (state_q == ST_RESP) && !rsp_valid;
    assign rsp_rdata = rd_sel_q ? ram_q : 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (access) begin
                rsp_valid <= 1'b1;
                rsp_err   <= fault;
                rd_sel_q  <= !fault && !we_q;
            end else if (rsp_hs) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rd_sel_q  <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (access && !fault),
        .we    (we_q ? wstrb_q : 4'd0),
        .addr  (offset[AW+1:2]),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

endmodule
